// File: rtl/pool_stream_out_if.sv
// Handshake/bus bundle for pool_stream_out: control, pooled-BRAM read port and output stream.
interface pool_stream_out_if #(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH_P = 56,
  parameter int AWIDTH   = 12
);
  logic                start_run_i;
  logic [CNT_BIT-1:0]  run_count_i;
  logic [DWIDTH_P-1:0] q_b1_i;
  logic                m_ready_i;
  logic                idle_o;
  logic                run_o;
  logic                done_o;
  logic [AWIDTH-1:0]   addr_b1_o;
  logic                ce_b1_o;
  logic                we_b1_o;
  logic                m_valid_o;
  logic [DWIDTH_P-1:0] m_data_o;
  logic                m_last_o;

  modport slave (
    input  start_run_i, run_count_i, q_b1_i, m_ready_i,
    output idle_o, run_o, done_o, addr_b1_o, ce_b1_o, we_b1_o,
           m_valid_o, m_data_o, m_last_o
  );

  modport master (
    output start_run_i, run_count_i, q_b1_i, m_ready_i,
    input  idle_o, run_o, done_o, addr_b1_o, ce_b1_o, we_b1_o,
           m_valid_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/pool_stream_out.sv
// Streams run_count pooled words from BRAM through a 2-entry credit-controlled FIFO.
// Optional macro POOL_STREAM_RELU_EN clamps negative signed lanes to zero at FIFO write.
module pool_stream_out #(
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH_P      = 56,
  parameter int AWIDTH        = 12,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  pool_stream_out_if.slave   bus
);

`ifdef POOL_STREAM_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif
  localparam int unsigned LANES = DWIDTH_P / IN_DATA_WIDTH;
  localparam logic [CNT_BIT-1:0] ONE = CNT_BIT'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_BIT-1:0]  r_count;
  logic [CNT_BIT-1:0]  r_rd_cnt;
  logic [CNT_BIT-1:0]  r_out_cnt;
  logic                r_inflight;
  logic [1:0]          r_fifo_cnt;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [DWIDTH_P-1:0] r_fifo_mem [2];

  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_last;
  logic                w_credit_ok;
  logic                w_issue;
  logic                w_to_done;
  logic [DWIDTH_P-1:0] w_push_data;

  assign w_valid     = (r_fifo_cnt != 2'd0);
  assign w_pop       = w_valid & bus.m_ready_i;
  assign w_push      = r_inflight;
  assign w_last      = w_valid & (r_out_cnt == (r_count - ONE));
  // Buffered + in-flight words after this cycle's pop must leave room for one more read.
  assign w_credit_ok = ({1'b0, r_fifo_cnt} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop});
  assign w_issue     = (r_state == S_RUN) && (r_rd_cnt < r_count) && w_credit_ok;
  assign w_to_done   = (w_next == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start_run_i) w_next = (bus.run_count_i != '0) ? S_RUN : S_DONE;
      S_RUN:   if (w_pop && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.idle_o = 1'b0;
    bus.run_o  = 1'b0;
    bus.done_o = 1'b0;
    unique case (r_state)
      S_IDLE:  bus.idle_o = 1'b1;
      S_RUN:   bus.run_o  = 1'b1;
      S_DONE:  bus.done_o = 1'b1;
      default: bus.idle_o = 1'b1;
    endcase
  end

  always_comb begin
    w_push_data = bus.q_b1_i;
    if (RELU_EN) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (bus.q_b1_i[i*IN_DATA_WIDTH + IN_DATA_WIDTH - 1])
          w_push_data[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count        <= '0;
      r_rd_cnt       <= '0;
      r_out_cnt      <= '0;
      r_inflight     <= 1'b0;
      r_fifo_cnt     <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_fifo_mem[0]  <= '0;
      r_fifo_mem[1]  <= '0;
    end else if (w_to_done) begin
      r_count        <= '0;
      r_rd_cnt       <= '0;
      r_out_cnt      <= '0;
      r_inflight     <= 1'b0;
      r_fifo_cnt     <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_fifo_mem[0]  <= '0;
      r_fifo_mem[1]  <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start_run_i) begin
        r_count   <= bus.run_count_i;
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
      end
      if (w_issue) r_rd_cnt <= r_rd_cnt + ONE;
      r_inflight <= w_issue;
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr  <= ~r_rd_ptr;
        r_out_cnt <= r_out_cnt + ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // The read counter ends one past the last word; hold the address at count-1 then.
  assign bus.addr_b1_o = AWIDTH'(((r_rd_cnt == r_count) && (r_rd_cnt != '0)) ? (r_rd_cnt - ONE) : r_rd_cnt);
  assign bus.ce_b1_o   = w_issue;
  assign bus.we_b1_o   = 1'b0;
  assign bus.m_valid_o = w_valid;
  assign bus.m_data_o  = r_fifo_mem[r_rd_ptr];
  assign bus.m_last_o  = w_last;

endmodule

// File: tb/tb_pool_stream_out.sv
// Directed bench for pool_stream_out: cycle table for a 4-word run plus multi-cycle scenarios.
module tb_pool_stream_out;
  localparam int CNT_BIT  = 31;
  localparam int DWIDTH_P = 56;
  localparam int AWIDTH   = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pool_stream_out_if #(.CNT_BIT(CNT_BIT), .DWIDTH_P(DWIDTH_P), .AWIDTH(AWIDTH)) bus ();

  pool_stream_out #(
    .CNT_BIT(CNT_BIT), .DWIDTH_P(DWIDTH_P), .AWIDTH(AWIDTH), .IN_DATA_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [55:0] mem      [16];
  logic [55:0] exp_data [16];

  // One-cycle-latency BRAM model.
  always @(posedge clk) if (bus.ce_b1_o) bus.q_b1_i <= mem[bus.addr_b1_o[3:0]];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_idle"},  bus.idle_o,    1'b1);
    check1({tag, "_run"},   bus.run_o,     1'b0);
    check1({tag, "_done"},  bus.done_o,    1'b0);
    check1({tag, "_ce"},    bus.ce_b1_o,   1'b0);
    check1({tag, "_we"},    bus.we_b1_o,   1'b0);
    check1({tag, "_valid"}, bus.m_valid_o, 1'b0);
    check1({tag, "_last"},  bus.m_last_o,  1'b0);
    check({tag, "_addr"},   64'(bus.addr_b1_o), 64'd0);
    check({tag, "_data"},   64'(bus.m_data_o),  64'd0);
  endtask

  // Runs one stream; returns the cycle index of done_o (or -1). stop_after>0 returns
  // at the negedge where that many words have been accepted.
  task automatic stream(input int n, input bit toggle, input bit glitch,
                        input int stop_after, output int done_cyc);
    int issued = 0;
    int acc = 0;
    int cyc = 0;
    bit held = 1'b0;
    bit seen = 1'b0;
    logic [55:0] held_data = '0;
    logic [3:0] ai;
    done_cyc = -1;
    bus.start_run_i = 1'b1;
    bus.run_count_i = CNT_BIT'(n);
    bus.m_ready_i   = 1'b1;
    while (cyc < 80 && !seen) begin
      @(negedge clk);
      if (held) begin
        check1("hold_valid", bus.m_valid_o, 1'b1);
        check("hold_data", 64'(bus.m_data_o), 64'(held_data));
      end
      held = 1'b0;
      if (bus.ce_b1_o) begin
        check("addr", 64'(bus.addr_b1_o), 64'(issued));
        issued++;
      end
      if (bus.m_valid_o) begin
        check1("last", bus.m_last_o, acc == n - 1);
        if (bus.m_ready_i) begin
          ai = 4'(acc);
          check("data", 64'(bus.m_data_o), 64'(exp_data[ai]));
          acc++;
        end else begin
          held = 1'b1;
          held_data = bus.m_data_o;
        end
      end
      check1("outstanding_le2", (issued - acc) <= 2, 1'b1);
      if (bus.done_o) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
      if (stop_after != 0 && acc == stop_after) return;
      @(posedge clk); #1;
      cyc++;
      bus.start_run_i = glitch && (cyc == 2);
      if (glitch && cyc == 2) bus.run_count_i = CNT_BIT'(9);
      bus.m_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
    end
    check1("done_seen", seen, 1'b1);
    check("accepted", 64'(acc), 64'(n));
    check("issued", 64'(issued), 64'(n));
    check1("idle_after_done", bus.idle_o, 1'b1);
  endtask

  typedef struct {
    logic        start;
    logic [30:0] cnt;
    logic        rdy;
    logic [3:0]  flags;   // idle, run, done, ce
    logic [11:0] addr;
    logic        valid;
    logic [55:0] data;
    logic        last;
  } vec_t;

  vec_t vec [9];
  int   dc;

  initial begin
    vec[0] = '{1'b1, 31'd4, 1'b1, 4'b1000, 12'd0, 1'b0, 56'h0,  1'b0};
    vec[1] = '{1'b0, 31'd4, 1'b1, 4'b0101, 12'd0, 1'b0, 56'h0,  1'b0};
    vec[2] = '{1'b0, 31'd4, 1'b1, 4'b0101, 12'd1, 1'b0, 56'h0,  1'b0};
    vec[3] = '{1'b0, 31'd4, 1'b1, 4'b0101, 12'd2, 1'b1, 56'h11, 1'b0};
    vec[4] = '{1'b0, 31'd4, 1'b1, 4'b0101, 12'd3, 1'b1, 56'h12, 1'b0};
    vec[5] = '{1'b0, 31'd4, 1'b1, 4'b0100, 12'd3, 1'b1, 56'h13, 1'b0};
    vec[6] = '{1'b0, 31'd4, 1'b1, 4'b0100, 12'd3, 1'b1, 56'h14, 1'b1};
    vec[7] = '{1'b0, 31'd4, 1'b1, 4'b0010, 12'd0, 1'b0, 56'h0,  1'b0};
    vec[8] = '{1'b0, 31'd4, 1'b1, 4'b1000, 12'd0, 1'b0, 56'h0,  1'b0};

    for (int i = 0; i < 16; i++) begin
      mem[i]      = 56'h11 + 56'(i);
      exp_data[i] = 56'h11 + 56'(i);
    end
    bus.start_run_i = 1'b0;
    bus.run_count_i = '0;
    bus.m_ready_i   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // count=4, ready high: cycle-exact table
    for (int i = 0; i < 9; i++) begin
      bus.start_run_i = vec[i].start;
      bus.run_count_i = vec[i].cnt;
      bus.m_ready_i   = vec[i].rdy;
      @(negedge clk);
      check1($sformatf("c%0d_idle", i), bus.idle_o,  vec[i].flags[3]);
      check1($sformatf("c%0d_run", i),  bus.run_o,   vec[i].flags[2]);
      check1($sformatf("c%0d_done", i), bus.done_o,  vec[i].flags[1]);
      check1($sformatf("c%0d_ce", i),   bus.ce_b1_o, vec[i].flags[0]);
      check($sformatf("c%0d_addr", i),  64'(bus.addr_b1_o), 64'(vec[i].addr));
      check1($sformatf("c%0d_valid", i), bus.m_valid_o, vec[i].valid);
      check1($sformatf("c%0d_last", i),  bus.m_last_o,  vec[i].last);
      if (vec[i].valid) check($sformatf("c%0d_data", i), 64'(bus.m_data_o), 64'(vec[i].data));
      @(posedge clk); #1;
    end

    // count=8, ready toggling 1,0
    stream(8, 1'b1, 1'b0, 0, dc);

    // count=0: straight to DONE, no reads
    stream(0, 1'b0, 1'b0, 0, dc);
    check("cnt0_done_cycle", 64'(dc), 64'd1);

    // start pulsed mid-run with a different count is ignored
    stream(5, 1'b0, 1'b1, 0, dc);
    check("glitch_done_cycle", 64'(dc), 64'd8);

    // reset after the 3rd accepted word of a 6-word run
    stream(6, 1'b0, 1'b0, 3, dc);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    bus.start_run_i = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("postrst_idle", bus.idle_o, 1'b1);
      check1("postrst_ce", bus.ce_b1_o, 1'b0);
      check1("postrst_valid", bus.m_valid_o, 1'b0);
    end
    @(posedge clk); #1;
    stream(2, 1'b0, 1'b0, 0, dc);
    check("restart_done_cycle", 64'(dc), 64'd5);

    // ReLU word
    mem[0] = 56'h80_7F_FF_01_00_90_05;
`ifdef POOL_STREAM_RELU_EN
    exp_data[0] = 56'h00_7F_00_01_00_00_05;
`else
    exp_data[0] = 56'h80_7F_FF_01_00_90_05;
`endif
    stream(1, 1'b0, 1'b0, 0, dc);
    check("relu_done_cycle", 64'(dc), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
